// File: rtl/fir_pkg.sv
// Shared types and codebase-wide defaults for the FIR accumulator slice.
package fir_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } acc_state_t;

    localparam int FIR_WIDTH = 16;
    localparam int FIR_TAPS  = 8;

endpackage

// File: rtl/fir_accumulator.sv
// MAC accumulator and tap sequencer around an external adder; result on valid/ready.
// Optional FIR_ACC_SATURATE_EN: clamp to all-ones on wrap instead of storing the wrapped sum.
module fir_accumulator
    import fir_pkg::*;
#(
    parameter int WIDTH = FIR_WIDTH,
    parameter int TAPS  = FIR_TAPS,
    parameter int IDX_W = $clog2(TAPS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mac_en,
    input  logic [WIDTH-1:0] suma_wynik,
    output logic [WIDTH-1:0] Acc_out,
    output logic [IDX_W-1:0] tap_idx,
    output logic             busy,
    output logic [WIDTH-1:0] wynik,
    output logic             wynik_valid,
    input  logic             wynik_ready,
    output logic             overflow
);

    acc_state_t       r_state;
    logic             w_wrap;
    logic             w_last;
    logic [WIDTH-1:0] w_acc_next;

    // The adder wraps modulo 2^WIDTH, so an unsigned add that lands below the old value wrapped.
    assign w_wrap = (suma_wynik < Acc_out);
    assign w_last = (tap_idx == IDX_W'(TAPS - 1));

`ifdef FIR_ACC_SATURATE_EN
    // Sticky overflow keeps the sample pinned at all-ones once it has clipped.
    assign w_acc_next = (w_wrap || overflow) ? '1 : suma_wynik;
`else
    assign w_acc_next = suma_wynik;
`endif

    assign busy = (r_state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            Acc_out     <= '0;
            tap_idx     <= '0;
            wynik       <= '0;
            wynik_valid <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        Acc_out  <= '0;
                        tap_idx  <= '0;
                        overflow <= 1'b0;
                        r_state  <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (mac_en) begin
                        if (w_wrap)
                            overflow <= 1'b1;
                        if (w_last) begin
                            wynik       <= w_acc_next;
                            wynik_valid <= 1'b1;
                            Acc_out     <= '0;
                            tap_idx     <= '0;
                            r_state     <= DONE;
                        end else begin
                            Acc_out <= w_acc_next;
                            tap_idx <= tap_idx + IDX_W'(1);
                        end
                    end
                end
                DONE: begin
                    // start is deliberately ignored here; a new sample must begin from IDLE.
                    if (wynik_ready) begin
                        wynik_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fir_accumulator.sv
// Directed + randomized bench for fir_accumulator with the adder modelled as a wrapping add.
module tb_fir_accumulator;

    localparam int W    = 16;
    localparam int TAPS = 4;
    localparam int IW   = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          start = 1'b0;
    logic          mac_en = 1'b0;
    logic          wynik_ready = 1'b0;
    logic [W-1:0]  prod = '0;
    logic [W-1:0]  suma_wynik;
    logic [W-1:0]  Acc_out;
    logic [IW-1:0] tap_idx;
    logic          busy;
    logic [W-1:0]  wynik;
    logic          wynik_valid;
    logic          overflow;

    int unsigned   prods [TAPS];
    logic [W-1:0]  exp_w;
    logic          exp_ov;
    int            n_tests = 0;
    int            n_fail  = 0;

    always #5 clk = ~clk;

    assign suma_wynik = prod + Acc_out;

    fir_accumulator #(.WIDTH(W), .TAPS(TAPS), .IDX_W(IW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mac_en(mac_en),
        .suma_wynik(suma_wynik), .Acc_out(Acc_out), .tap_idx(tap_idx),
        .busy(busy), .wynik(wynik), .wynik_valid(wynik_valid),
        .wynik_ready(wynik_ready), .overflow(overflow)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: true integer sum; any crossing of 2^W means a wrap happened somewhere.
    task automatic model();
        longint sum = 0;
        for (int k = 0; k < TAPS; k++) sum += prods[k];
        exp_ov = (sum >= (longint'(1) << W));
`ifdef FIR_ACC_SATURATE_EN
        exp_w = exp_ov ? {W{1'b1}} : W'(sum);
`else
        exp_w = W'(sum);
`endif
    endtask

    task automatic do_sample(input int stall_at, input int stall_len);
        model();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        chk("acc_cleared", Acc_out, 0);
        chk("ovf_cleared", overflow, 0);
        for (int k = 0; k < TAPS; k++) begin
            if (k == stall_at) begin
                for (int s = 0; s < stall_len; s++) begin
                    mac_en = 1'b0;
                    tick();
                    chk("stall_tap_hold", tap_idx, k);
                    chk("stall_valid_low", wynik_valid, 0);
                end
            end
            chk("tap_idx", tap_idx, k);
            chk("valid_early", wynik_valid, 0);
            mac_en = 1'b1;
            prod   = prods[k][W-1:0];
            tick();
        end
        mac_en = 1'b0;
        prod   = '0;
        chk("valid_rise", wynik_valid, 1);
        chk("wynik", wynik, exp_w);
        chk("overflow", overflow, exp_ov);
        chk("acc_zero_done", Acc_out, 0);
        chk("tap_zero_done", tap_idx, 0);
        chk("busy_done", busy, 1);
    endtask

    task automatic release_out(input int hold, input bit pulse_start);
        wynik_ready = 1'b0;
        for (int i = 0; i < hold; i++) begin
            start = pulse_start && (i == hold / 2);
            tick();
            start = 1'b0;
            chk("hold_wynik", wynik, exp_w);
            chk("hold_valid", wynik_valid, 1);
            chk("hold_busy", busy, 1);
            chk("hold_ovf", overflow, exp_ov);
        end
        wynik_ready = 1'b1;
        tick();
        wynik_ready = 1'b0;
        chk("valid_drop", wynik_valid, 0);
        chk("idle_after_ready", busy, 0);
        chk("wynik_kept", wynik, exp_w);
    endtask

    initial begin
        #2 rst_n = 1'b0;
        #1;
        chk("rst_acc", Acc_out, 0);
        chk("rst_tap", tap_idx, 0);
        chk("rst_wynik", wynik, 0);
        chk("rst_valid", wynik_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ovf", overflow, 0);
        tick();
        tick();
        #2 rst_n = 1'b1;
        tick();

        // Basic sample.
        prods = '{10, 5, 200, 55};
        do_sample(-1, 0);
        release_out(0, 1'b0);

        // Stall between products 2 and 3.
        tick();
        do_sample(2, 3);
        release_out(0, 1'b0);

        // Large but non-wrapping.
        prods = '{60000, 500, 0, 0};
        do_sample(-1, 0);
        release_out(1, 1'b0);

        // Wrapping sample, long hold with an ignored start pulse.
        prods = '{60000, 5600, 1, 1};
        do_sample(-1, 0);
        release_out(10, 1'b1);

        // Reset mid-ACCUM after two taps.
        prods = '{100, 200, 300, 400};
        start = 1'b1;
        tick();
        start  = 1'b0;
        mac_en = 1'b1;
        prod   = 16'd100;
        tick();
        prod = 16'd200;
        tick();
        mac_en = 1'b0;
        prod   = '0;
        rst_n  = 1'b0;
        #1;
        chk("midrst_acc", Acc_out, 0);
        chk("midrst_tap", tap_idx, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_valid", wynik_valid, 0);
        chk("midrst_wynik", wynik, 0);
        tick();
        #2 rst_n = 1'b1;
        tick();
        do_sample(-1, 0);
        release_out(2, 1'b0);

        // Back-to-back: start alongside ready in DONE must be ignored.
        prods = '{1, 2, 3, 4};
        do_sample(-1, 0);
        wynik_ready = 1'b1;
        start       = 1'b1;
        tick();
        wynik_ready = 1'b0;
        start       = 1'b0;
        chk("b2b_start_ignored", busy, 0);
        chk("b2b_valid_drop", wynik_valid, 0);
        tick();
        chk("b2b_still_idle", busy, 0);
        prods = '{7, 8, 9, 10};
        do_sample(-1, 0);
        release_out(0, 1'b0);

        // Randomized samples with random stalls and hold times.
        for (int r = 0; r < 12; r++) begin
            for (int k = 0; k < TAPS; k++)
                prods[k] = (r % 2 == 0) ? $urandom_range(0, 65535) : $urandom_range(0, 4000);
            do_sample(int'($urandom_range(0, TAPS)), int'($urandom_range(0, 3)));
            release_out(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 1) tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
